// File: rtl/serdes_link.sv
// serdes_link: framed serial transmitter plus receiver (start 0, data, [parity], stop 1), one bit per clock.
// Define SERDES_LINK_PARITY_EN to insert and check an even-parity bit after the data field.
module serdes_link #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    input  logic              ser_in,
    input  logic              loop_sel,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overflow,
    output logic              rx_frame_err,
    output logic              rx_perr
);

`ifdef SERDES_LINK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_DATA, RX_PARITY, RX_STOP, RX_HUNT
    } rx_state_t;

    tx_state_t         tx_state;
    logic [DATA_W-1:0] tx_sh;
    logic [CNT_W-1:0]  tx_cnt;
    logic              tx_par;

    rx_state_t         rx_state;
    logic [DATA_W-1:0] rx_sh;
    logic [CNT_W-1:0]  rx_cnt;
    logic              rx_par_acc;
    logic              rx_perr_flag;
    logic              rx_perr_q;
    logic              rx_line;

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    // Handshake: a word transfers on any rising edge where tx_valid && tx_ready; tx_ready
    // is high in IDLE and STOP, so a word offered during STOP follows with no idle gap.
    // The state name describes the bit currently driven on ser_out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
            ser_out  <= 1'b1;
            tx_sh    <= '0;
            tx_cnt   <= '0;
            tx_par   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE, TX_STOP: begin
                    if (tx_valid) begin
                        tx_sh    <= tx_data;
                        tx_par   <= ^tx_data;
                        ser_out  <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_state <= TX_START;
                    end else begin
                        ser_out  <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                TX_START: begin
                    ser_out  <= head_bit(tx_sh);
                    tx_sh    <= shift_out(tx_sh);
                    tx_cnt   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_cnt == LAST_BIT) begin
                        if (PAR_EN) begin
                            ser_out  <= tx_par;
                            tx_state <= TX_PARITY;
                        end else begin
                            ser_out  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_state <= TX_STOP;
                        end
                    end else begin
                        ser_out <= head_bit(tx_sh);
                        tx_sh   <= shift_out(tx_sh);
                        tx_cnt  <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_PARITY: begin
                    ser_out  <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_state <= TX_STOP;
                end
                default: begin
                    ser_out  <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign rx_line = loop_sel ? ser_out : ser_in;

    // The state name describes which field the next sample is expected to carry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state     <= RX_IDLE;
            rx_sh        <= '0;
            rx_cnt       <= '0;
            rx_par_acc   <= 1'b0;
            rx_perr_flag <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_perr_q    <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            if (rx_ack && rx_valid) begin
                rx_valid    <= 1'b0;
                rx_overflow <= 1'b0;
                rx_perr_q   <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_line) begin
                        rx_cnt     <= '0;
                        rx_par_acc <= 1'b0;
                        rx_state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_sh      <= MSB_FIRST ? {rx_sh[DATA_W-2:0], rx_line}
                                            : {rx_line, rx_sh[DATA_W-1:1]};
                    rx_par_acc <= rx_par_acc ^ rx_line;
                    if (rx_cnt == LAST_BIT) begin
                        rx_perr_flag <= 1'b0;
                        rx_state     <= PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_PARITY: begin
                    rx_perr_flag <= rx_par_acc ^ rx_line;
                    rx_state     <= RX_STOP;
                end
                RX_STOP: begin
                    if (rx_line) begin
                        rx_state <= RX_IDLE;
                        // Overrides the ack clear above: a word acked on this edge is replaced.
                        if (!rx_valid || rx_ack) begin
                            rx_data     <= rx_sh;
                            rx_valid    <= 1'b1;
                            rx_overflow <= 1'b0;
                            rx_perr_q   <= rx_perr_flag;
                        end else begin
                            rx_overflow <= 1'b1;
                        end
                    end else begin
                        rx_frame_err <= 1'b1;
                        rx_state     <= RX_HUNT;
                    end
                end
                RX_HUNT: begin
                    if (rx_line) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_perr = PAR_EN ? rx_perr_q : 1'b0;

endmodule

// File: tb/tb_serdes_link.sv
// Bench for serdes_link: LSB-first and MSB-first instances share stimulus and are checked against a frame model.
// Define SERDES_LINK_PARITY_EN to also exercise the parity bit.
module tb_serdes_link;

    localparam int W = 8;
`ifdef SERDES_LINK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = W + 2 + PAR;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [W-1:0] tx_data;
    logic         tx_valid, ser_in, loop_sel, rx_ack;
    logic         a_tx_ready, a_ser_out, a_rx_valid, a_rx_overflow, a_rx_frame_err, a_rx_perr;
    logic         b_tx_ready, b_ser_out, b_rx_valid, b_rx_overflow, b_rx_frame_err, b_rx_perr;
    logic [W-1:0] a_rx_data, b_rx_data;
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           failures = 0;

    always #5 CLK = ~CLK;

    serdes_link #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(a_tx_ready),
        .ser_out(a_ser_out), .ser_in(ser_in), .loop_sel(loop_sel), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_ack(rx_ack), .rx_overflow(a_rx_overflow),
        .rx_frame_err(a_rx_frame_err), .rx_perr(a_rx_perr)
    );

    serdes_link #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(b_tx_ready),
        .ser_out(b_ser_out), .ser_in(ser_in), .loop_sel(loop_sel), .rx_data(b_rx_data),
        .rx_valid(b_rx_valid), .rx_ack(rx_ack), .rx_overflow(b_rx_overflow),
        .rx_frame_err(b_rx_frame_err), .rx_perr(b_rx_perr)
    );

    // Bit j of the frame carrying w: start 0, data in the chosen order, optional even parity, stop 1.
    function automatic logic frame_bit(input logic [W-1:0] w, input bit msb, input int j);
        if (j == 0) return 1'b0;
        if (j <= W) return msb ? w[W-j] : w[j-1];
        if (PAR == 1 && j == W + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] reverse(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    // ---------------- clock/reset and driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_tx_ready();
        int n = 0;
        while (!(a_tx_ready && b_tx_ready) && n < 4 * F) begin
            step();
            n++;
        end
        if (!(a_tx_ready && b_tx_ready)) begin
            checks++; failures++;
            $display("FAIL tx_ready_timeout got=%b/%b exp=1/1", a_tx_ready, b_tx_ready);
        end
    endtask

    // Returns 1ns after the accept edge.
    task automatic accept_word(input logic [W-1:0] w);
        wait_tx_ready();
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = W'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ack = 1'b0; loop_sel = 1'b1; ser_in = 1'b1;
        step(); step();
        checks++; if ({a_ser_out, a_tx_ready, a_rx_valid, a_rx_overflow, a_rx_frame_err, a_rx_perr} !== 6'b110000) begin
            failures++; $display("FAIL reset_flags_lsb got=%b exp=110000", {a_ser_out, a_tx_ready, a_rx_valid, a_rx_overflow, a_rx_frame_err, a_rx_perr}); end
        checks++; if ({b_ser_out, b_tx_ready, b_rx_valid, b_rx_overflow, b_rx_frame_err, b_rx_perr} !== 6'b110000) begin
            failures++; $display("FAIL reset_flags_msb got=%b exp=110000", {b_ser_out, b_tx_ready, b_rx_valid, b_rx_overflow, b_rx_frame_err, b_rx_perr}); end
        checks++; if (a_rx_data !== '0 || b_rx_data !== '0) begin
            failures++; $display("FAIL reset_rx_data got=%h/%h exp=00/00", a_rx_data, b_rx_data); end
        RST_N = 1'b1;
        step(); step();
    endtask

    task automatic test_loopback();
        logic [W-1:0] w, e;
        loop_sel = 1'b1;
        for (int n = 0; n < 6; n++) begin
            w = (n == 0) ? 8'hA5 : W'($urandom);
            exp_q.push_back(w);
            accept_word(w);
            for (int j = 0; j < F; j++) begin
                checks++; if (a_ser_out !== frame_bit(w, 1'b0, j)) begin
                    failures++; $display("FAIL loop_ser_out_lsb w=%h j=%0d got=%b exp=%b", w, j, a_ser_out, frame_bit(w, 1'b0, j)); end
                checks++; if (b_ser_out !== frame_bit(w, 1'b1, j)) begin
                    failures++; $display("FAIL loop_ser_out_msb w=%h j=%0d got=%b exp=%b", w, j, b_ser_out, frame_bit(w, 1'b1, j)); end
                checks++; if (a_rx_valid !== 1'b0 || b_rx_valid !== 1'b0) begin
                    failures++; $display("FAIL loop_early_valid j=%0d got=%b/%b exp=0/0", j, a_rx_valid, b_rx_valid); end
                tx_data = W'($urandom);
                step();
            end
            e = exp_q.pop_front();
            checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== e || a_rx_perr !== 1'b0) begin
                failures++; $display("FAIL loop_rx_lsb got=v%b d=%h p%b exp=v1 d=%h p0", a_rx_valid, a_rx_data, a_rx_perr, e); end
            checks++; if (b_rx_valid !== 1'b1 || b_rx_data !== e || b_rx_perr !== 1'b0) begin
                failures++; $display("FAIL loop_rx_msb got=v%b d=%h p%b exp=v1 d=%h p0", b_rx_valid, b_rx_data, b_rx_perr, e); end
            rx_ack = 1'b1; step(); rx_ack = 1'b0;
            checks++; if (a_rx_valid !== 1'b0 || b_rx_valid !== 1'b0) begin
                failures++; $display("FAIL loop_ack_clear got=%b/%b exp=0/0", a_rx_valid, b_rx_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2, e;
        logic         eb_a, eb_b;
        loop_sel = 1'b1;
        for (int n = 0; n < 3; n++) begin
            w1 = (n == 0) ? 8'h3C : W'($urandom);
            w2 = (n == 0) ? 8'hC3 : W'($urandom);
            exp_q.push_back(w1);
            exp_q.push_back(w2);
            wait_tx_ready();
            tx_data = w1; tx_valid = 1'b1;
            step();
            tx_data = w2;
            for (int j = 0; j < 2 * F; j++) begin
                rx_ack = 1'b0;
                eb_a = (j < F) ? frame_bit(w1, 1'b0, j) : frame_bit(w2, 1'b0, j - F);
                eb_b = (j < F) ? frame_bit(w1, 1'b1, j) : frame_bit(w2, 1'b1, j - F);
                checks++; if (a_ser_out !== eb_a || b_ser_out !== eb_b) begin
                    failures++; $display("FAIL b2b_ser_out j=%0d got=%b/%b exp=%b/%b", j, a_ser_out, b_ser_out, eb_a, eb_b); end
                checks++; if (a_tx_ready !== (j == F - 1 || j == 2 * F - 1)) begin
                    failures++; $display("FAIL b2b_tx_ready j=%0d got=%b exp=%b", j, a_tx_ready, (j == F - 1 || j == 2 * F - 1)); end
                if (j == F) begin
                    tx_valid = 1'b0; tx_data = W'($urandom);
                    e = exp_q.pop_front();
                    checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== e || b_rx_valid !== 1'b1 || b_rx_data !== e) begin
                        failures++; $display("FAIL b2b_first_word got=%b:%h/%b:%h exp=1:%h", a_rx_valid, a_rx_data, b_rx_valid, b_rx_data, e); end
                    rx_ack = 1'b1;
                end
                step();
            end
            rx_ack = 1'b0;
            e = exp_q.pop_front();
            checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== e || b_rx_valid !== 1'b1 || b_rx_data !== e) begin
                failures++; $display("FAIL b2b_second_word got=%b:%h/%b:%h exp=1:%h", a_rx_valid, a_rx_data, b_rx_valid, b_rx_data, e); end
            rx_ack = 1'b1; step(); rx_ack = 1'b0;
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] w1, w2, w3, w4;
        loop_sel = 1'b1;
        w1 = W'($urandom); w2 = ~w1; w3 = W'($urandom); w4 = w3 ^ 8'h5A;
        accept_word(w1); repeat (F) step();
        accept_word(w2); repeat (F) step();
        checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== w1 || a_rx_overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_keep_lsb got=v%b d=%h o%b exp=v1 d=%h o1", a_rx_valid, a_rx_data, a_rx_overflow, w1); end
        checks++; if (b_rx_valid !== 1'b1 || b_rx_data !== w1 || b_rx_overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_keep_msb got=v%b d=%h o%b exp=v1 d=%h o1", b_rx_valid, b_rx_data, b_rx_overflow, w1); end
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
        checks++; if ({a_rx_valid, a_rx_overflow, b_rx_valid, b_rx_overflow} !== 4'b0000) begin
            failures++; $display("FAIL ovf_ack_clear got=%b exp=0000", {a_rx_valid, a_rx_overflow, b_rx_valid, b_rx_overflow}); end
        // ack on the delivery edge: the new word replaces the old one without overflow
        accept_word(w3); repeat (F) step();
        accept_word(w4); repeat (F - 1) step();
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
        checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== w4 || a_rx_overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_same_edge_lsb got=v%b d=%h o%b exp=v1 d=%h o0", a_rx_valid, a_rx_data, a_rx_overflow, w4); end
        checks++; if (b_rx_valid !== 1'b1 || b_rx_data !== w4 || b_rx_overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_same_edge_msb got=v%b d=%h o%b exp=v1 d=%h o0", b_rx_valid, b_rx_data, b_rx_overflow, w4); end
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
    endtask

    task automatic test_framing_error();
        logic [W-1:0] w;
        logic         bit_v;
        loop_sel = 1'b0; ser_in = 1'b1;
        step(); step();
        w = W'($urandom);
        for (int j = 0; j < F; j++) begin
            ser_in = (j == F - 1) ? 1'b0 : frame_bit(w, 1'b0, j);
            step();
            checks++; if (a_rx_frame_err !== (j == F - 1) || b_rx_frame_err !== (j == F - 1)) begin
                failures++; $display("FAIL ferr_pulse j=%0d got=%b/%b exp=%b", j, a_rx_frame_err, b_rx_frame_err, (j == F - 1)); end
            checks++; if (a_rx_valid !== 1'b0 || b_rx_valid !== 1'b0) begin
                failures++; $display("FAIL ferr_valid j=%0d got=%b/%b exp=0/0", j, a_rx_valid, b_rx_valid); end
        end
        for (int j = 0; j < 5; j++) begin
            step();
            checks++; if ({a_rx_frame_err, a_rx_valid, b_rx_frame_err, b_rx_valid} !== 4'b0000) begin
                failures++; $display("FAIL ferr_hunt j=%0d got=%b exp=0000", j, {a_rx_frame_err, a_rx_valid, b_rx_frame_err, b_rx_valid}); end
        end
        ser_in = 1'b1; step();
        w = W'($urandom);
        for (int j = 0; j < F; j++) begin
            bit_v = frame_bit(w, 1'b0, j);
            ser_in = bit_v;
            step();
            checks++; if (a_rx_valid !== (j == F - 1) || b_rx_valid !== (j == F - 1)) begin
                failures++; $display("FAIL ferr_recover_valid j=%0d got=%b/%b exp=%b", j, a_rx_valid, b_rx_valid, (j == F - 1)); end
        end
        checks++; if (a_rx_data !== w || b_rx_data !== reverse(w) || a_rx_perr !== 1'b0 || b_rx_perr !== 1'b0) begin
            failures++; $display("FAIL ferr_recover_data got=%h/%h p%b%b exp=%h/%h p00", a_rx_data, b_rx_data, a_rx_perr, b_rx_perr, w, reverse(w)); end
        ser_in = 1'b1;
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] w0, w1;
        loop_sel = 1'b1; ser_in = 1'b1;
        w0 = W'($urandom); w1 = W'($urandom);
        accept_word(w0); repeat (F) step();
        accept_word(w1); repeat (5) step();
        checks++; if (a_ser_out !== frame_bit(w1, 1'b0, 5)) begin
            failures++; $display("FAIL rst_bit4 got=%b exp=%b", a_ser_out, frame_bit(w1, 1'b0, 5)); end
        #1 RST_N = 1'b0;
        #1;
        checks++; if ({a_ser_out, a_tx_ready, a_rx_valid, b_ser_out, b_tx_ready, b_rx_valid} !== 6'b110110) begin
            failures++; $display("FAIL rst_async got=%b exp=110110", {a_ser_out, a_tx_ready, a_rx_valid, b_ser_out, b_tx_ready, b_rx_valid}); end
        checks++; if (a_rx_data !== '0 || b_rx_data !== '0) begin
            failures++; $display("FAIL rst_async_data got=%h/%h exp=00/00", a_rx_data, b_rx_data); end
        step();
        RST_N = 1'b1;
        step();
        accept_word(8'h5A);
        for (int j = 0; j < F; j++) begin
            checks++; if (a_rx_valid !== 1'b0 || b_rx_valid !== 1'b0) begin
                failures++; $display("FAIL rst_stale_valid j=%0d got=%b/%b exp=0/0", j, a_rx_valid, b_rx_valid); end
            step();
        end
        checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== 8'h5A || b_rx_valid !== 1'b1 || b_rx_data !== 8'h5A) begin
            failures++; $display("FAIL rst_next_word got=%b:%h/%b:%h exp=1:5a", a_rx_valid, a_rx_data, b_rx_valid, b_rx_data); end
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
    endtask

    task automatic test_loop_sel_glitch();
        logic [W-1:0] w;
        for (int n = 0; n < 3; n++) begin
            loop_sel = 1'b1; ser_in = 1'b1;
            accept_word(W'($urandom));
            repeat ($urandom_range(1, F - 2)) step();
            loop_sel = 1'b0;
            for (int j = 0; j < 3; j++) begin
                ser_in = 1'($urandom);
                step();
            end
            ser_in = 1'b1; loop_sel = 1'b1;
            repeat (2 * F + 2) step();
            rx_ack = 1'b1; step(); rx_ack = 1'b0;
            checks++; if ({a_rx_valid, a_rx_overflow, b_rx_valid, b_rx_overflow} !== 4'b0000) begin
                failures++; $display("FAIL glitch_drain n=%0d got=%b exp=0000", n, {a_rx_valid, a_rx_overflow, b_rx_valid, b_rx_overflow}); end
            w = W'($urandom);
            accept_word(w); repeat (F) step();
            checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== w || b_rx_valid !== 1'b1 || b_rx_data !== w) begin
                failures++; $display("FAIL glitch_recover n=%0d got=%b:%h/%b:%h exp=1:%h", n, a_rx_valid, a_rx_data, b_rx_valid, b_rx_data, w); end
            rx_ack = 1'b1; step(); rx_ack = 1'b0;
        end
    endtask

`ifdef SERDES_LINK_PARITY_EN
    task automatic test_parity();
        loop_sel = 1'b1; ser_in = 1'b1;
        accept_word(8'h07);
        for (int j = 0; j < F; j++) begin
            if (j == W + 1) begin
                checks++; if (a_ser_out !== 1'b1 || b_ser_out !== 1'b1) begin
                    failures++; $display("FAIL par_tx_bit got=%b/%b exp=1/1", a_ser_out, b_ser_out); end
            end
            step();
        end
        checks++; if (a_rx_data !== 8'h07 || a_rx_perr !== 1'b0 || b_rx_perr !== 1'b0) begin
            failures++; $display("FAIL par_clean got=%h p%b%b exp=07 p00", a_rx_data, a_rx_perr, b_rx_perr); end
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
        loop_sel = 1'b0;
        for (int j = 0; j < F; j++) begin
            ser_in = (j == W + 1) ? ~frame_bit(8'h07, 1'b0, j) : frame_bit(8'h07, 1'b0, j);
            step();
        end
        ser_in = 1'b1;
        checks++; if (a_rx_valid !== 1'b1 || a_rx_data !== 8'h07 || a_rx_perr !== 1'b1) begin
            failures++; $display("FAIL par_flip_lsb got=v%b d=%h p%b exp=v1 d=07 p1", a_rx_valid, a_rx_data, a_rx_perr); end
        checks++; if (b_rx_valid !== 1'b1 || b_rx_data !== reverse(8'h07) || b_rx_perr !== 1'b1) begin
            failures++; $display("FAIL par_flip_msb got=v%b d=%h p%b exp=v1 d=%h p1", b_rx_valid, b_rx_data, b_rx_perr, reverse(8'h07)); end
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
        checks++; if (a_rx_perr !== 1'b0 || b_rx_perr !== 1'b0) begin
            failures++; $display("FAIL par_ack_clear got=%b/%b exp=0/0", a_rx_perr, b_rx_perr); end
        loop_sel = 1'b1;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_overflow();
        test_framing_error();
        test_reset_mid_frame();
        test_loop_sel_glitch();
`ifdef SERDES_LINK_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serdes_link.md
Name: serdes_link

Overview:
- Parametrised framed serial link: a parallel-to-serial transmitter and a serial-to-parallel receiver in one block, clocked by CLK.
- TX takes a DATA_W-bit word on a valid/ready handshake and shifts out one framed bit per clock.
- RX samples either its own TX line (loopback) or an external serial input, reassembles the word, and holds it until acknowledged.
- Adds start/stop framing, flow control, framing-error and overflow detection, selectable bit order and optional parity.

Parameters:
DATA_W, 8, payload bits per frame (2..32)
MSB_FIRST, 0, 0 = LSB shifted first, 1 = MSB shifted first (TX and RX identical)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX can accept a word this cycle
ser_out  output  1  registered serial line, idles high
ser_in  input  1  external serial input, same clock domain
loop_sel  input  1  1 = RX samples ser_out internally, 0 = RX samples ser_in
rx_data  output  DATA_W  last received word
rx_valid  output  1  rx_data holds an unacknowledged word
rx_ack  input  1  consumer accepts rx_data
rx_overflow  output  1  a frame was dropped while rx_valid was high
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_perr  output  1  parity error for the word in rx_data

Behaviour:
- Reset (RST_N low, asynchronous) forces:
  - ser_out=1, tx_ready=1, rx_valid=0, rx_data=0.
  - rx_overflow=0, rx_frame_err=0, rx_perr=0.
  - Both FSMs go to IDLE and the bit counters clear.
- Reset mid-frame aborts the frame; nothing is delivered.
- Frame format: start 0, DATA_W data bits, [parity], stop 1. Frame length F = DATA_W+2 (+1 with parity).
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - tx_ready=1 in IDLE and STOP only.
  - A word is accepted at an edge where tx_valid&&tx_ready. The word is latched into the shift register and the state goes to START.
  - Accepting in STOP gives back-to-back frames with no idle gap.
  - Accept at edge k: start bit on ser_out after edge k; data bit i after edge k+1+i; stop bit after edge k+F-1.
  - tx_data changes after acceptance do not affect the frame in flight.
- RX FSM: IDLE -> DATA -> [PARITY] -> STOP -> IDLE, plus HUNT. Sampling is one sample per clock of the selected line, with no oversampling.
  - IDLE: a sampled 0 starts a frame.
  - DATA: shifts in DATA_W bits using the order given by MSB_FIRST.
  - STOP, sampled 1: frame is good.
  - STOP, sampled 0: pulse rx_frame_err, discard the frame, go to HUNT.
  - HUNT: waits for a sampled 1, then goes to IDLE.
- Loopback latency: rx_valid rises DATA_W+2 edges after the TX accept edge (+1 with parity).
- Good-frame delivery:
  - If rx_valid=0, or rx_ack=1 on the same edge: load rx_data and set rx_valid=1. The new word wins; no overflow.
  - If rx_valid=1 and rx_ack=0: drop the new frame, keep the old rx_data, set rx_overflow.
- rx_ack while rx_valid=1 clears rx_valid, rx_overflow and rx_perr. rx_ack while rx_valid=0 is ignored.
- loop_sel is sampled every cycle with no protection. Changing it mid-frame may corrupt the frame or cause a framing error; the block must not lock up.

Optional Feature:
- Macro: SERDES_LINK_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of the data bits) after the data.
  - RX checks it. The word is still delivered on a mismatch; rx_perr=1 alongside rx_valid.
  - F = DATA_W+3.
- Undefined:
  - No parity bit is sent or checked; rx_perr is tied to 0.
  - F = DATA_W+2.

Test Plan:
1. DATA_W=8, LSB-first, loop_sel=1, send 0xA5, rx_ack held 0 → ser_out sequence 0,1,0,1,0,0,1,0,1,1; rx_valid rises 10 edges after accept; rx_data=0xA5.
2. MSB_FIRST=1, send 0x3C then 0xC3 with tx_valid held high → the second frame starts immediately after the first stop bit with no gap; rx_ack after each word; both words received in order.
3. Send two words without rx_ack → rx_data keeps the first word, rx_overflow=1. Assert rx_ack → rx_valid=0, rx_overflow=0.
4. loop_sel=0, drive ser_in with a start bit, 8 bits, then stop bit 0 → one-cycle rx_frame_err, rx_valid stays 0. Hold ser_in low 5 cycles, then high; the next valid frame is received correctly.
5. Assert RST_N low mid-frame during TX bit 4 → immediately ser_out=1, tx_ready=1, rx_valid=0. The next sent word 0x5A is received intact.
6. With SERDES_LINK_PARITY_EN: send 0x07 → parity bit 1 on ser_out. Inject a parity flip via ser_in → rx_data=0x07, rx_valid=1, rx_perr=1.
